// File: rtl/uart_test_ctrl_pkg.sv
// Shared definitions for the UART host command decoder: ASCII command and
// reply bytes, the FSM state encoding and a nibble-to-hex helper.
package uart_test_ctrl_pkg;

    // Host commands
    localparam logic [7:0] CMD_GO     = 8'h47;  // 'G'
    localparam logic [7:0] CMD_HALT   = 8'h48;  // 'H'
    localparam logic [7:0] CMD_CLEAR  = 8'h43;  // 'C'
    localparam logic [7:0] CMD_STATUS = 8'h53;  // 'S'

    // Reply bytes
    localparam logic [7:0] RSP_OK   = 8'h4B;    // 'K'
    localparam logic [7:0] RSP_ERR  = 8'h3F;    // '?'
    localparam logic [7:0] RSP_RUN  = 8'h52;    // 'R'
    localparam logic [7:0] RSP_HALT = 8'h48;    // 'H'
    localparam logic [7:0] LF       = 8'h0A;

    typedef enum logic [1:0] {
        StIdle,
        StDecode,
        StClear,
        StSend
    } state_e;

    // 0-9 map to '0'-'9', 10-15 map to uppercase 'A'-'F'
    function automatic logic [7:0] nibble_to_hex(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else begin
            return 8'h37 + {4'h0, nib};
        end
    endfunction

endpackage

// File: rtl/uart_test_ctrl.sv
// Host command decoder for the LUT-RAM test designs. Decodes single-byte
// commands from the UART receiver, drives run/clear control into the test
// engine, counts completed passes and sends short ASCII replies.
module uart_test_ctrl
    import uart_test_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = 4,
    parameter logic        RUN_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] rx_data,
    input  logic       rx_data_ready,
    input  logic       loop_complete,
    output logic [7:0] tx_data,
    output logic       tx_data_ready,
    input  logic       tx_data_accepted,
    output logic       test_run,
    output logic       test_rst,
    output logic [7:0] loop_count,
    output logic       overrun
);

    localparam int unsigned CntW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_e          state;
    logic [7:0]      rx_byte;
    logic [3:0][7:0] rsp_buf;   // entry 0 is sent first
    logic [1:0]      rsp_idx;
    logic [1:0]      rsp_last;  // index of the final reply byte
    logic [CntW-1:0] rst_cnt;

    // Command FSM with registered reply and engine-control outputs
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state         <= StIdle;
            rx_byte       <= 8'h00;
            rsp_buf       <= '0;
            rsp_idx       <= 2'd0;
            rsp_last      <= 2'd0;
            rst_cnt       <= '0;
            tx_data       <= 8'h00;
            tx_data_ready <= 1'b0;
            test_run      <= RUN_ON_RESET;
            test_rst      <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (rx_data_ready) begin
                        rx_byte <= rx_data;
                        state   <= StDecode;
                    end
                end

                StDecode: begin
                    rsp_idx  <= 2'd0;
                    rsp_last <= 2'd0;
                    rsp_buf  <= {8'h00, 8'h00, 8'h00, RSP_OK};
                    case (rx_byte)
                        CMD_GO: begin
                            test_run      <= 1'b1;
                            tx_data       <= RSP_OK;
                            tx_data_ready <= 1'b1;
                            state         <= StSend;
                        end
                        CMD_HALT: begin
                            test_run      <= 1'b0;
                            tx_data       <= RSP_OK;
                            tx_data_ready <= 1'b1;
                            state         <= StSend;
                        end
                        CMD_CLEAR: begin
                            test_rst <= 1'b1;
                            rst_cnt  <= '0;
                            state    <= StClear;
                        end
                        CMD_STATUS: begin
                            // Count is snapshotted here; later passes do not alter the reply
                            rsp_buf <= {LF,
                                        nibble_to_hex(loop_count[3:0]),
                                        nibble_to_hex(loop_count[7:4]),
                                        test_run ? RSP_RUN : RSP_HALT};
                            rsp_last      <= 2'd3;
                            tx_data       <= test_run ? RSP_RUN : RSP_HALT;
                            tx_data_ready <= 1'b1;
                            state         <= StSend;
                        end
                        default: begin
                            tx_data       <= RSP_ERR;
                            tx_data_ready <= 1'b1;
                            state         <= StSend;
                        end
                    endcase
                end

                StClear: begin
                    // Hold test_rst for RST_CYCLES, then one quiet cycle before the 'K'
                    if (test_rst) begin
                        if (rst_cnt == CntW'(RST_CYCLES - 1)) begin
                            test_rst <= 1'b0;
                        end else begin
                            rst_cnt <= rst_cnt + 1'b1;
                        end
                    end else begin
                        tx_data       <= rsp_buf[0];
                        tx_data_ready <= 1'b1;
                        state         <= StSend;
                    end
                end

                StSend: begin
                    if (tx_data_accepted) begin
                        if (rsp_idx == rsp_last) begin
                            tx_data_ready <= 1'b0;
                            state         <= StIdle;
                        end else begin
                            rsp_idx <= rsp_idx + 2'd1;
                            tx_data <= rsp_buf[rsp_idx + 2'd1];
                        end
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

    // Pass counter and sticky overrun flag; an active clear overrides both
    always_ff @(posedge clk) begin
        if (!nrst) begin
            loop_count <= 8'h00;
            overrun    <= 1'b0;
        end else if (state == StClear) begin
            loop_count <= 8'h00;
            overrun    <= 1'b0;
        end else begin
            if (loop_complete && test_run && (loop_count != 8'hFF)) begin
                loop_count <= loop_count + 8'd1;
            end
            if (rx_data_ready && (state != StIdle)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_test_ctrl.sv
// Self-checking bench for uart_test_ctrl: expected reply bytes are queued by
// the stimulus and popped by a monitor on every accepted byte.
module tb_uart_test_ctrl;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic       loop_complete;
    logic [7:0] tx_data;
    logic       tx_data_ready;
    logic       tx_data_accepted;
    logic       test_run;
    logic       test_rst;
    logic [7:0] loop_count;
    logic       overrun;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    uart_test_ctrl #(
        .RST_CYCLES  (4),
        .RUN_ON_RESET(1'b1)
    ) dut (
        .clk             (clk),
        .nrst            (nrst),
        .rx_data         (rx_data),
        .rx_data_ready   (rx_data_ready),
        .loop_complete   (loop_complete),
        .tx_data         (tx_data),
        .tx_data_ready   (tx_data_ready),
        .tx_data_accepted(tx_data_accepted),
        .test_run        (test_run),
        .test_rst        (test_rst),
        .loop_count      (loop_count),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data       = b;
        rx_data_ready = 1'b1;
        @(negedge clk);
        rx_data_ready = 1'b0;
    endtask

    task automatic loop_pulse(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            loop_complete = 1'b1;
            @(negedge clk);
            loop_complete = 1'b0;
        end
    endtask

    task automatic wait_ready(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (tx_data_ready) seen = 1'b1;
            else @(negedge clk);
        end
        check({name, "_ready_timeout"}, seen, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (!tx_data_ready && exp_q.size() == 0) done = 1'b1;
        end
        check({name, "_idle_timeout"}, done, 1'b1);
    endtask

    // Monitor: sample just before each rising edge, pop on every accepted byte
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (nrst && tx_data_ready && tx_data_accepted) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_byte: got %02h, none expected", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data === e) n_pass++;
                    else $display("FAIL reply_byte: got %02h, expected %02h", tx_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int rdy;
        int changes;
        logic [7:0] held;

        nrst             = 1'b0;
        rx_data          = 8'h00;
        rx_data_ready    = 1'b0;
        loop_complete    = 1'b0;
        tx_data_accepted = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_tx_ready", tx_data_ready, 1'b0);
        check("rst_test_run", test_run, 1'b1);
        check("rst_test_rst", test_rst, 1'b0);
        check("rst_loop_count", loop_count, 8'h00);
        check("rst_overrun", overrun, 1'b0);
        nrst = 1'b1;
        @(negedge clk);

        // 'H' halts: test_run drops at N+2 with a 'K' offered
        exp_q.push_back(8'h4B);
        send_byte(8'h48);
        check("halt_run_n1", test_run, 1'b1);
        @(negedge clk);
        check("halt_run_n2", test_run, 1'b0);
        check("halt_ready_n2", tx_data_ready, 1'b1);
        wait_idle("halt");

        // 'G' restarts
        exp_q.push_back(8'h4B);
        send_byte(8'h47);
        wait_idle("go");
        check("go_run", test_run, 1'b1);

        // Three passes then status, stalling byte 2 for 5 cycles
        loop_pulse(3);
        check("count3", loop_count, 8'h03);
        tx_data_accepted = 1'b0;
        exp_q.push_back(8'h52);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h0A);
        send_byte(8'h53);
        wait_ready("stat3");
        tx_data_accepted = 1'b1;
        @(negedge clk);
        tx_data_accepted = 1'b0;
        held    = tx_data;
        changes = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (tx_data !== held || !tx_data_ready) changes++;
        end
        check("stall_byte2", held, 8'h30);
        check("stall_stable", changes, 0);
        tx_data_accepted = 1'b1;
        wait_idle("stat3");

        // Saturation at 0xFF
        loop_pulse(300);
        check("count_sat", loop_count, 8'hFF);
        exp_q.push_back(8'h52);
        exp_q.push_back(8'h46);
        exp_q.push_back(8'h46);
        exp_q.push_back(8'h0A);
        send_byte(8'h53);
        wait_idle("stat_ff");

        // Clear: test_rst high for exactly 4 cycles from N+2, pass mid-clear ignored
        exp_q.push_back(8'h4B);
        send_byte(8'h43);
        check("clr_rst_n1", test_rst, 1'b0);
        hi  = 0;
        rdy = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (test_rst) hi++;
            if (tx_data_ready) rdy++;
            loop_complete = (i == 1);
        end
        loop_complete = 1'b0;
        check("clr_rst_width", hi, 4);
        check("clr_no_reply_early", rdy, 0);
        @(negedge clk);
        check("clr_rst_drop", test_rst, 1'b0);
        check("clr_count", loop_count, 8'h00);
        wait_idle("clear");
        check("clr_run_kept", test_run, 1'b1);

        // Unknown command
        exp_q.push_back(8'h3F);
        send_byte(8'h78);
        wait_idle("unknown");
        check("unk_run", test_run, 1'b1);
        check("unk_count", loop_count, 8'h00);

        // Byte arriving mid-reply is dropped and flagged
        tx_data_accepted = 1'b0;
        exp_q.push_back(8'h52);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h0A);
        send_byte(8'h53);
        wait_ready("ovr");
        send_byte(8'h48);
        check("ovr_flag", overrun, 1'b1);
        tx_data_accepted = 1'b1;
        wait_idle("ovr");
        repeat (5) @(negedge clk);
        check("ovr_run_kept", test_run, 1'b1);
        exp_q.push_back(8'h4B);
        send_byte(8'h43);
        wait_idle("ovr_clear");
        check("ovr_cleared", overrun, 1'b0);

        // Reset in the middle of a status reply
        loop_pulse(2);
        exp_q.push_back(8'h4B);
        send_byte(8'h48);
        wait_idle("pre_rst_halt");
        check("pre_rst_count", loop_count, 8'h02);
        tx_data_accepted = 1'b0;
        exp_q.push_back(8'h48);
        send_byte(8'h53);
        wait_ready("rst_mid");
        tx_data_accepted = 1'b1;
        @(negedge clk);
        tx_data_accepted = 1'b0;
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        check("mid_rst_tx_data", tx_data, 8'h00);
        check("mid_rst_ready", tx_data_ready, 1'b0);
        check("mid_rst_run", test_run, 1'b1);
        check("mid_rst_count", loop_count, 8'h00);
        tx_data_accepted = 1'b1;
        rdy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_data_ready) rdy++;
        end
        check("mid_rst_no_more", rdy, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
